// File: rtl/scan_acc_pkg.sv
// Shared types and constants for the scan accumulator: FSM state encoding and
// the mode select values.
package scan_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

endpackage : scan_acc_pkg

// File: rtl/scan_accumulator_chan_mux.sv
// CH:1 x W channel mux with an index-to-one-hot decoder on the same index;
// a parametrised generalisation of the old 4:1 mux and 2:4 decoder.
module chan_mux #(
  parameter int W    = 4,
  parameter int CH   = 4,
  parameter int SELW = $clog2(CH)
) (
  input  logic [CH*W-1:0] data_i,
  input  logic [SELW-1:0] idx_i,
  output logic [W-1:0]    data_o,
  output logic [CH-1:0]   onehot_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    data_o   = '0;
    onehot_o = '0;
    for (int k = 0; k < CH; k++) begin
      if (idx_i == SELW'(k)) begin
        data_o      = data_i[k*W +: W];
        onehot_o[k] = 1'b1;
      end
    end
  end

endmodule : chan_mux

// File: rtl/scan_accumulator.sv
// Sequential channel accumulator: sums CH samples (round-robin or one fixed
// channel) and hands the total to the display side over valid/ready.
module scan_accumulator
  import scan_acc_pkg::*;
#(
  parameter int W    = 4,
  parameter int CH   = 4,
  parameter int SELW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   din,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic [CH-1:0]     onehot,
  output logic [W+SELW-1:0] sum,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int             SW       = W + SELW;
  localparam logic [SELW-1:0] CNT_LAST = SELW'(CH - 1);

  state_e            state_q;
  logic [SELW-1:0]   cnt_q;
  logic [SELW-1:0]   sel_q;
  logic              mode_q;
  logic [SW-1:0]     acc_q;
  logic [SW-1:0]     acc_d;
  logic              out_valid_q;

  logic [SELW-1:0]   ch;
  logic [W-1:0]      sample;
  logic [CH-1:0]     decode;

  assign ch = (mode_q == MODE_SCAN) ? cnt_q : sel_q;

  chan_mux #(
    .W   (W),
    .CH  (CH),
    .SELW(SELW)
  ) u_chan_mux (
    .data_i  (din),
    .idx_i   (ch),
    .data_o  (sample),
    .onehot_o(decode)
  );

  // CH * (2^W - 1) always fits in W+SELW bits, so the add never carries out.
  assign acc_d = acc_q + SW'(sample);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      mode_q      <= MODE_FIXED;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            acc_q   <= '0;
            mode_q  <= mode;
            sel_q   <= sel;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign onehot    = busy ? decode : '0;
  assign sum       = acc_q;
  assign out_valid = out_valid_q;

endmodule : scan_accumulator

// File: tb/tb_scan_accumulator.sv
// Self-checking bench for scan_accumulator: directed boundary cases plus
// randomized passes against a sum-of-selected-samples reference model.
module tb_scan_accumulator;

  localparam int W  = 4;
  localparam int CH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst;
  logic [15:0] din;
  logic        mode;
  logic [1:0]  sel;
  logic        start, clear, out_ready;
  logic        busy;
  logic [3:0]  onehot;
  logic [5:0]  sum;
  logic        out_valid;

  // W=8, CH=8 instance
  logic [63:0] din_b;
  logic        mode_b;
  logic [2:0]  sel_b;
  logic        start_b, clear_b, out_ready_b;
  logic        busy_b;
  logic [7:0]  onehot_b;
  logic [10:0] sum_b;
  logic        out_valid_b;

  int vectors     = 0;
  int miscompares = 0;

  scan_accumulator #(.W(W), .CH(CH)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .sel(sel),
    .start(start), .clear(clear), .busy(busy), .onehot(onehot),
    .sum(sum), .out_valid(out_valid), .out_ready(out_ready)
  );

  scan_accumulator #(.W(8), .CH(8)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .mode(mode_b), .sel(sel_b),
    .start(start_b), .clear(clear_b), .busy(busy_b), .onehot(onehot_b),
    .sum(sum_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},   64'(busy),      64'd0);
    check({tag, ".onehot"}, 64'(onehot),    64'd0);
    check({tag, ".valid"},  64'(out_valid), 64'd0);
  endtask

  // One complete pass. seq[i] is the din value live during the i-th RUN cycle.
  // poke drives start and changes mode/sel while the pass is in flight; all of
  // it must be ignored.
  task automatic run_pass(input logic m, input logic [1:0] s,
                          input logic [3:0][15:0] seq, input int stall, input bit poke);
    int exp_sum;
    int ch;
    check("pass.idle_before", 64'(busy), 64'd0);
    mode  = m;
    sel   = s;
    din   = seq[0];
    start = 1'b1;
    step();
    start   = 1'b0;
    exp_sum = 0;
    for (int i = 0; i < CH; i++) begin
      ch  = m ? i : int'(s);
      din = seq[i];
      if (poke) begin
        mode  = ~m;
        sel   = s + 2'd1;
        start = 1'b1;
      end
      check("run.busy",   64'(busy),      64'd1);
      check("run.onehot", 64'(onehot),    64'(1 << ch));
      check("run.valid",  64'(out_valid), 64'd0);
      exp_sum += int'(seq[i][ch*W +: W]);
      step();
    end
    start     = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j < stall; j++) begin
      if (poke) start = 1'b1;
      check("done.stall_valid", 64'(out_valid), 64'd1);
      check("done.stall_sum",   64'(sum),       64'(exp_sum));
      check("done.stall_busy",  64'(busy),      64'd0);
      step();
    end
    out_ready = 1'b1;
    start     = poke;
    check("done.valid",  64'(out_valid), 64'd1);
    check("done.sum",    64'(sum),       64'(exp_sum));
    check("done.onehot", 64'(onehot),    64'd0);
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check_idle("after_handshake");
    step();
    check("after_handshake.start_ignored", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [3:0][15:0] seq;
    int               exp_b;

    rst = 1'b1; din = '0; mode = 1'b0; sel = '0; start = 1'b0; clear = 1'b0; out_ready = 1'b0;
    din_b = '0; mode_b = 1'b0; sel_b = '0; start_b = 1'b0; clear_b = 1'b0; out_ready_b = 1'b0;
    step();
    step();
    check_idle("reset");
    check("reset.sum", 64'(sum), 64'd0);
    rst = 1'b0;
    step();
    check_idle("post_reset");

    // Scan with ch0..3 = 1,2,3,4
    for (int i = 0; i < CH; i++) seq[i] = 16'h4321;
    run_pass(1'b1, 2'd0, seq, 0, 1'b0);

    // Fixed channel 2 at maximum value, ready already high
    for (int i = 0; i < CH; i++) seq[i] = 16'h0F00;
    run_pass(1'b0, 2'd2, seq, 0, 1'b1);

    // Backpressure with start pulses and mode/sel changes during the pass
    for (int i = 0; i < CH; i++) seq[i] = 16'h4321;
    run_pass(1'b1, 2'd0, seq, 5, 1'b1);

    // Clear on the second RUN cycle
    mode = 1'b1; din = 16'h4321; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("clear.onehot_before", 64'(onehot), 64'b0010);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_idle("clear");
    check("clear.acc", 64'(sum), 64'd0);
    for (int i = 0; i < CH + 2; i++) begin
      step();
      check("clear.no_valid", 64'(out_valid), 64'd0);
    end

    // Reset in the middle of a pass
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_mid_run");
    check("rst_mid_run.sum", 64'(sum), 64'd0);
    step();

    // Live data: ch1 changes 2 -> 7 on its own scan cycle, so 1+7+3+4
    seq[0] = 16'h4321; seq[1] = 16'h4371; seq[2] = 16'h4371; seq[3] = 16'h4371;
    run_pass(1'b1, 2'd0, seq, 1, 1'b0);

    // Randomized passes
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < CH; i++) seq[i] = 16'($urandom);
      run_pass(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), seq,
               int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
    end

    // Wide instance: all channels at 255 in scan, then a random fixed pass
    din_b = '1; mode_b = 1'b1; start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("wide.onehot", 64'(onehot_b), 64'(1 << i));
      step();
    end
    check("wide.valid", 64'(out_valid_b), 64'd1);
    check("wide.sum",   64'(sum_b),       64'd2040);
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
    check("wide.idle", 64'(out_valid_b), 64'd0);

    mode_b = 1'b0; sel_b = 3'($urandom_range(0, 7)); start_b = 1'b1;
    step();
    start_b = 1'b0;
    exp_b   = 0;
    for (int i = 0; i < 8; i++) begin
      din_b = {$urandom, $urandom};
      exp_b += int'(din_b[int'(sel_b)*8 +: 8]);
      check("wide_fixed.onehot", 64'(onehot_b), 64'(1 << int'(sel_b)));
      step();
    end
    check("wide_fixed.sum", 64'(sum_b), 64'(exp_b));
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
    check("wide_fixed.idle", 64'(out_valid_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_scan_accumulator
